uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- Parametrised UART transmitter; next generation of the fixed 8-bit transmitter.
- Adds generic data width, optional odd/even parity, 1 or 2 stop bits, an internal baud divider and a synchronous reset.
- Sits between a byte/word producer and the serial pad.
- Keeps the existing start/busy/done handshake so current producers drop in unchanged.

Parameters:
- CLOCK_RATE, 50000000: clk frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s. CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE (integer division), which gives 434 at the defaults. CLKS_PER_BIT must be at least 2.
- DATA_BITS, 8: payload width. Legal range 5 to 9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: legal values 1 or 2.

Ports:
- clk  input  1  system clock; everything is rising-edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global enable. When low, the baud counter and FSM freeze.
- start  input  1  request to transmit `in`. Sampled only in IDLE.
- in  input  DATA_BITS  payload, captured on the accepting edge.
- out  output  1  serial line. Idles high.
- busy  output  1  high while a frame is in flight.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-frame):
  - Next cycle: out=1, busy=0, done=0, state=IDLE, baud counter=0, bit index=0.
  - rst has priority over en and start.
- Acceptance:
  - In IDLE with en=1 and start=1 at edge N, in is latched into a shift register.
  - From cycle N+1: state=START, out=0, busy=1.
  - While busy, start is ignored and changes on `in` do not affect the frame.
- Baud counter:
  - Counts 0 to CLKS_PER_BIT-1 while en=1 and not IDLE.
  - The terminal count advances the FSM. Every bit lasts exactly CLKS_PER_BIT enabled cycles.
- FSM sequence: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - START: out=0 for one bit time.
  - DATA: out = shift register LSB; the register shifts right at each bit end. Runs for DATA_BITS bit times, LSB first.
  - PARITY: present only when PARITY≠0. out = XOR of the latched payload, inverted for odd parity, so the total count of ones including parity is odd (odd) or even (even).
  - STOP: out=1 for STOP_BITS bit times.
- Frame length:
  - (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT enabled cycles, from the first START cycle to the last STOP cycle inclusive.
- Completion:
  - On the edge ending the last stop bit, the next cycle has state=IDLE, busy=0, done=1 for exactly one cycle, out=1.
  - Back-to-back: start=1 during the done cycle is accepted. The next START begins the following cycle, with no extra idle gap.
- Enable:
  - en=0 holds the state, counter, shift register and out.
  - done is cleared while en=0.
  - start is not accepted while en=0.
  - Elapsed bit time resumes exactly where it paused.
- Width rules:
  - Baud counter width = clog2(CLKS_PER_BIT).
  - Bit index width = clog2(DATA_BITS+1).
  - No counter may wrap except the baud counter at terminal count.

Test Plan:
1. Defaults (8N1, CLKS_PER_BIT=434), in=0x55, start for 1 cycle -> out = 0,1,0,1,0,1,0,1,0,1, each held 434 cycles; busy high for 4340 cycles; done pulses once, one cycle after the last stop cycle.
2. PARITY=2, in=0x96 -> parity bit 0; repeat with PARITY=1 -> parity bit 1; frame length 11 bits.
3. DATA_BITS=7, STOP_BITS=2, PARITY=0, CLOCK_RATE=16, BAUD_RATE=1 (CLKS_PER_BIT=16), in=0x41 -> bits 0,1,0,0,0,0,0,1,1,1, each 16 cycles; done at cycle 161 after acceptance.
4. start re-pulsed and in changed to 0xFF mid-frame -> ignored; transmitted data stays 0x55. Then start held high through the done cycle -> second frame's start bit appears the cycle after done, with no idle gap.
5. en=0 for 100 cycles during data bit 3 -> out frozen and frame extended by exactly 100 cycles. Separately, en=0 with start=1 in IDLE -> no frame starts.
6. rst=1 for 1 cycle during data bit 5 -> next cycle out=1, busy=0, done=0; no done pulse for the aborted frame; a new start after reset transmits a full, correct frame.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter.
// Frame = start bit, DATA_BITS payload bits sent LSB first, an optional
// parity bit, then STOP_BITS stop bits. Each bit lasts CLOCK_RATE/BAUD_RATE
// enabled clock cycles. The start/busy/done handshake matches the older
// fixed 8-bit transmitter. All outputs are registered.
module uart_tx_frame #(
    parameter int CLOCK_RATE = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] in,
    output logic                 out,
    output logic                 busy,
    output logic                 done
);

    localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    // Odd parity is the inverse of the payload XOR.
    localparam logic ODD_INV    = (PARITY == 1) ? 1'b1 : 1'b0;
    localparam logic HAS_PARITY = (PARITY != 0) ? 1'b1 : 1'b0;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;

    logic [2:0]           state_n;
    logic [CNT_W-1:0]     baud_cnt_n;
    logic [IDX_W-1:0]     bit_idx_n;
    logic [DATA_BITS-1:0] shreg_n;
    logic                 par_bit_n;
    logic                 out_n;
    logic                 busy_n;
    logic                 done_n;
    logic                 bit_end;

    assign bit_end = (baud_cnt == CNT_LAST);

    // Next-state logic: accept in IDLE, otherwise step the bit timer and
    // advance the frame at each bit end; everything holds while en is low.
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        par_bit_n  = par_bit;
        out_n      = out;
        busy_n     = busy;
        done_n     = 1'b0;
        if (!en) begin
            done_n = 1'b0;
        end else if (state == S_IDLE) begin
            out_n      = 1'b1;
            busy_n     = 1'b0;
            baud_cnt_n = '0;
            bit_idx_n  = '0;
            if (start) begin
                shreg_n   = in;
                par_bit_n = (^in) ^ ODD_INV;
                state_n   = S_START;
                out_n     = 1'b0;
                busy_n    = 1'b1;
            end else begin
                state_n = S_IDLE;
            end
        end else if (!bit_end) begin
            baud_cnt_n = baud_cnt + CNT_W'(1);
        end else begin
            baud_cnt_n = '0;
            case (state)
                S_START: begin
                    state_n   = S_DATA;
                    out_n     = shreg[0];
                    bit_idx_n = '0;
                end
                S_DATA: begin
                    if (bit_idx == DATA_LAST) begin
                        bit_idx_n = '0;
                        if (HAS_PARITY) begin
                            state_n = S_PARITY;
                            out_n   = par_bit;
                        end else begin
                            state_n = S_STOP;
                            out_n   = 1'b1;
                        end
                    end else begin
                        shreg_n   = {1'b0, shreg[DATA_BITS-1:1]};
                        out_n     = shreg[1];
                        bit_idx_n = bit_idx + IDX_W'(1);
                    end
                end
                S_PARITY: begin
                    state_n   = S_STOP;
                    out_n     = 1'b1;
                    bit_idx_n = '0;
                end
                S_STOP: begin
                    if (bit_idx == STOP_LAST) begin
                        state_n   = S_IDLE;
                        out_n     = 1'b1;
                        busy_n    = 1'b0;
                        done_n    = 1'b1;
                        bit_idx_n = '0;
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                    end
                end
                default: begin
                    state_n    = S_IDLE;
                    out_n      = 1'b1;
                    busy_n     = 1'b0;
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            out      <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shreg    <= shreg_n;
            par_bit  <= par_bit_n;
            out      <= out_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame. Four instances:
//   0: defaults (8N1, 434 clocks/bit)
//   1: 7 data bits, 2 stop bits, no parity, 16 clocks/bit
//   2: 8 data bits, even parity, 4 clocks/bit
//   3: 8 data bits, odd parity, 4 clocks/bit
// Expected frames are written as {stop bits, parity, payload, start bit},
// so bit 0 of each vector is the first bit on the line.
module tb_uart_tx_frame;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, en0, start0;
    logic [7:0] in0;
    logic       rst_s, en_s, st1, st2, st3;
    logic [7:0] inp;
    logic [3:0] out_v, busy_v, done_v;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_frame u0 (
        .clk(clk), .rst(rst0), .en(en0), .start(start0), .in(in0),
        .out(out_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    uart_tx_frame #(.CLOCK_RATE(16), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst_s), .en(en_s), .start(st1), .in(inp[6:0]),
        .out(out_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    uart_tx_frame #(.CLOCK_RATE(4), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst_s), .en(en_s), .start(st2), .in(inp),
        .out(out_v[2]), .busy(busy_v[2]), .done(done_v[2])
    );

    uart_tx_frame #(.CLOCK_RATE(4), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u3 (
        .clk(clk), .rst(rst_s), .en(en_s), .start(st3), .in(inp),
        .out(out_v[3]), .busy(busy_v[3]), .done(done_v[3])
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Compare {out, busy, done} of one instance right now.
    task automatic check_now(input int sel, input logic [2:0] exp, input string tag);
        logic [2:0] got;
        got = {out_v[sel], busy_v[sel], done_v[sel]};
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: {out,busy,done} got %b want %b", tag, got, exp);
        end
    endtask

    // For n consecutive cycles require out=lvl, busy=bsy, done=0.
    task automatic check_span(input int sel, input logic lvl, input logic bsy,
                              input int n, input string tag);
        int bad;
        int first_bad;
        bad = 0;
        first_bad = -1;
        for (int c = 0; c < n; c++) begin
            if (out_v[sel] !== lvl || busy_v[sel] !== bsy || done_v[sel] !== 1'b0) begin
                if (first_bad < 0) first_bad = c;
                bad++;
            end
            tick();
        end
        n_cmp++;
        assert (bad === 0) else begin
            n_err++;
            $error("FAIL %s: %0d bad cycles (first at %0d) of %0d, want 0 (out=%b busy=%b done=0)",
                   tag, bad, first_bad, n, lvl, bsy);
        end
    endtask

    // Check frame bits [lo..hi], each held cpb cycles.
    task automatic check_bits(input int sel, input int cpb, input logic [15:0] f,
                              input int lo, input int hi, input string tag);
        for (int b = lo; b <= hi; b++) begin
            check_span(sel, f[b], 1'b1, cpb, $sformatf("%s bit%0d", tag, b));
        end
    endtask

    logic [15:0] f;

    initial begin
        rst0 = 1'b1; en0 = 1'b1; start0 = 1'b0; in0 = 8'h00;
        rst_s = 1'b1; en_s = 1'b1; st1 = 1'b0; st2 = 1'b0; st3 = 1'b0; inp = 8'h00;
        tick();
        tick();
        // Reset state on every instance.
        for (int s = 0; s < 4; s++) begin
            check_now(s, 3'b100, $sformatf("reset u%0d", s));
        end
        rst0 = 1'b0;
        rst_s = 1'b0;
        tick();

        // 1: 8N1, 0x55 -> 0,1,0,1,0,1,0,1,0,1 at 434 clocks each.
        in0 = 8'h55; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        f = {6'd0, 1'b1, 8'h55, 1'b0};
        check_bits(0, 434, f, 0, 9, "t1");
        check_now(0, 3'b101, "t1 done");
        tick();
        check_now(0, 3'b100, "t1 after done");

        // 2: 0x96 has four ones -> even parity 0, odd parity 1.
        inp = 8'h96; st2 = 1'b1;
        tick();
        st2 = 1'b0;
        f = {5'd0, 1'b1, 1'b0, 8'h96, 1'b0};
        check_bits(2, 4, f, 0, 10, "t2 even");
        check_now(2, 3'b101, "t2 even done");
        tick();
        st3 = 1'b1;
        tick();
        st3 = 1'b0;
        f = {5'd0, 1'b1, 1'b1, 8'h96, 1'b0};
        check_bits(3, 4, f, 0, 10, "t2 odd");
        check_now(3, 3'b101, "t2 odd done");
        tick();

        // 3: 7N2 at 16 clocks/bit, 0x41 -> 0,1,0,0,0,0,0,1,1,1; done at +161.
        inp = 8'h41; st1 = 1'b1;
        tick();
        st1 = 1'b0;
        f = {6'd0, 2'b11, 7'h41, 1'b0};
        check_bits(1, 16, f, 0, 9, "t3");
        check_now(1, 3'b101, "t3 done");
        tick();
        check_now(1, 3'b100, "t3 after done");

        // 4: start and in=0xFF mid-frame are ignored; start held through done
        // launches the next frame (carrying 0xFF) without an idle gap.
        in0 = 8'h55; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        f = {6'd0, 1'b1, 8'h55, 1'b0};
        check_bits(0, 434, f, 0, 2, "t4a");
        start0 = 1'b1; in0 = 8'hFF;
        check_bits(0, 434, f, 3, 9, "t4a");
        check_now(0, 3'b101, "t4a done");
        tick();
        start0 = 1'b0;
        f = {6'd0, 1'b1, 8'hFF, 1'b0};
        check_bits(0, 434, f, 0, 9, "t4b");
        check_now(0, 3'b101, "t4b done");
        tick();

        // 5: en low for 100 cycles inside payload bit 3 (0xA3 -> that bit is 0).
        in0 = 8'hA3; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        f = {6'd0, 1'b1, 8'hA3, 1'b0};
        check_bits(0, 434, f, 0, 3, "t5");
        check_span(0, f[4], 1'b1, 200, "t5 bit4 pre");
        en0 = 1'b0;
        check_span(0, f[4], 1'b1, 100, "t5 bit4 frozen");
        en0 = 1'b1;
        check_span(0, f[4], 1'b1, 234, "t5 bit4 post");
        check_bits(0, 434, f, 5, 9, "t5");
        check_now(0, 3'b101, "t5 done");
        tick();
        // start while disabled in IDLE must not launch a frame.
        en0 = 1'b0; start0 = 1'b1;
        check_span(0, 1'b1, 1'b0, 10, "t5 start while en=0");
        start0 = 1'b0; en0 = 1'b1;
        check_span(0, 1'b1, 1'b0, 5, "t5 idle after en");

        // 6: reset during payload bit 5 aborts the frame with no done pulse.
        in0 = 8'h3C; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        f = {6'd0, 1'b1, 8'h3C, 1'b0};
        check_bits(0, 434, f, 0, 5, "t6");
        check_span(0, f[6], 1'b1, 100, "t6 bit6 partial");
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        check_now(0, 3'b100, "t6 after rst");
        check_span(0, 1'b1, 1'b0, 2000, "t6 idle no done");
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check_bits(0, 434, f, 0, 9, "t6 refire");
        check_now(0, 3'b101, "t6 refire done");
        tick();
        check_now(0, 3'b100, "t6 final idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
